wb_queue_ctrl: RTL

- Writeback queue that buffers (rd, data) results from execution units and drains them, one per cycle, into the register file write port (write_enable/write_addr/write_data).
- Sits between the execute/memory stages and the register file, on the writer side of the register file's write interface.
- Provides combinational pending-write lookup for two source registers, so decode can stall or forward against writes still in the queue.

---
 rtl/wbq_pkg.sv | 16 +
 rtl/wbq_match.sv | 54 +++++
 rtl/wb_queue_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/wbq_pkg.sv
// Shared types for the writeback queue.
// XLEN   : register data width.
// REG_AW : register address width.
// wbq_entry_t : one queue slot {valid, rd, data}.
package wbq_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Pending-write lookup over the writeback queue entries.
// Finds whether any valid entry targets addr. It also returns the data of
// the youngest matching entry, which is the one closest to tail.
// Optional feature macro: WBQ_FORWARD_EN. When it is undefined, data is
// tied to 0 and no data mux is built.
// Ports:
//   entries : queue storage (valid, rd, data per slot)
//   tail    : write pointer; the slot at tail-1 is the youngest
//   addr    : queried register address (x0 never matches)
//   busy    : some valid entry targets addr
//   data    : youngest matching data, 0 on a miss
import wbq_pkg::*;

module wbq_match #(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wbq_entry_t        entries [DEPTH],
  input  logic [PW-1:0]     tail,
  input  logic [REG_AW-1:0] addr,
  output logic              busy,
  output logic [XLEN-1:0]   data
);

  logic [PW-1:0] idx;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1). A later hit
  // overrides an earlier one, so the youngest match wins. Invalid slots
  // never hit, so the walk is correct for any occupancy.
  always_comb begin
    busy = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (entries[idx].valid && (entries[idx].rd == addr) && (addr != '0)) begin
        busy = 1'b1;
`ifdef WBQ_FORWARD_EN
        data = entries[idx].data;
`endif
      end
    end
  end

`ifndef WBQ_FORWARD_EN
  // Data fields feed nothing here without forwarding.
  logic unused_data;
  always_comb begin
    unused_data = 1'b0;
    for (int k = 0; k < DEPTH; k++) unused_data = unused_data ^ (^entries[k].data);
  end
`endif

endmodule

// File: rtl/wb_queue_ctrl.sv
// Writeback queue between the execute/memory stages and the register file.
// It buffers (rd, data) results and drains one per granted cycle into the
// register-file write port. It also offers two pending-write lookups so
// that decode can stall or forward.
// Optional feature macro: WBQ_FORWARD_EN, which enables q_data1/q_data2
// forwarding. When it is undefined, both are tied to 0.
// Ports:
//   clk, reset           : clock, async active-high reset
//   flush                : drop all queued entries at the next edge
//   in_valid/in_ready    : producer handshake; in_rd, in_data is the payload
//   rf_grant             : register-file write port available
//   rf_we/rf_waddr/rf_wdata : register-file write port
//   q_addr1/2, q_busy1/2, q_data1/2 : pending-write lookups
//   count, full, empty   : occupancy
import wbq_pkg::*;

module wb_queue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  input  logic              rf_grant,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [REG_AW-1:0] q_addr1,
  input  logic [REG_AW-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic [XLEN-1:0]   q_data1,
  output logic [XLEN-1:0]   q_data2,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  wbq_entry_t    entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push_store;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign rf_we    = !empty && rf_grant && !flush;

  // An accepted x0 result completes the handshake but is not stored.
  assign push_store = in_valid && in_ready && !flush && (in_rd != '0);

  assign rf_waddr = empty ? '0 : entries[head].rd;
  assign rf_wdata = empty ? '0 : entries[head].data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // A pop and a push never touch the same slot. A pop needs a
      // non-empty queue and a push needs a non-full one.
      if (rf_we) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      if (push_store) begin
        entries[tail] <= '{valid: 1'b1, rd: in_rd, data: in_data};
        tail          <= tail + PW'(1);
      end
      case ({push_store, rf_we})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries),
    .tail    (tail),
    .addr    (q_addr1),
    .busy    (q_busy1),
    .data    (q_data1)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries),
    .tail    (tail),
    .addr    (q_addr2),
    .busy    (q_busy2),
    .data    (q_data2)
  );

endmodule
